// File: rtl/pd_mem_pkg.sv
// Shared types for the instruction/data memory arbiter: default widths,
// response owner tags and the single-port memory read/write encoding.
package pd_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Owner tag for a granted access; stores return nothing so they carry no owner.
  function automatic owner_e grant_owner(input logic f_gnt, input logic d_gnt, input logic d_we);
    owner_e own;
    own = OWN_NONE;
    if (d_gnt && !d_we) own = OWN_DATA;
    else if (f_gnt)     own = OWN_FETCH;
    return own;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch port, load/store port and single-port memory signals
// seen by imem_arbiter; slave is the arbiter side, master the core/memory side.
interface imem_arbiter_if
  import pd_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_flush;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read_write;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  f_req, f_addr, f_flush,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_data_out,
    output f_gnt, f_rvalid, f_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_address, mem_data_in, mem_read_write
  );

  modport master (
    output f_req, f_addr, f_flush,
    output d_req, d_we, d_addr, d_wdata,
    output mem_data_out,
    input  f_gnt, f_rvalid, f_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_address, mem_data_in, mem_read_write
  );

endinterface

// File: rtl/imem_arb_age.sv
// Fetch starvation counter: counts consecutive data grants that bypassed a
// live fetch request and flags when the fetch side must win the next cycle.
module imem_arb_age #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_f_req,
  input  logic i_f_flush,
  input  logic i_f_gnt,
  input  logic i_d_gnt,
  output logic o_starve
);

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;

  // A flushing fetch is not really waiting, so the count holds rather than grows.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_f_gnt || !i_f_req) begin
      r_cnt <= '0;
    end else if (i_d_gnt && !i_f_flush && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_starve = (r_cnt == LIMIT);

endmodule

// File: rtl/imem_arbiter.sv
// Fetch vs load/store arbiter for one single-port memory with a two-stage
// response owner pipeline. Optional fetch starvation guard: FETCH_STARVE_GUARD_EN.
module imem_arbiter
  import pd_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  imem_arbiter_if.slave bus
);

  logic              w_f_ok;
  logic              w_starve;
  logic              w_f_gnt;
  logic              w_d_gnt;
  logic              w_kill1;
  logic              w_f_rvalid;
  logic              w_d_rvalid;

  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  owner_e            r_own1;
  owner_e            r_own2;
  logic [DATA_W-1:0] r_f_cap;
  logic [DATA_W-1:0] r_f_hold;
  logic [DATA_W-1:0] r_d_rdata;

  assign w_f_ok  = bus.f_req & ~bus.f_flush;
  assign w_d_gnt = ~reset & bus.d_req & ~(w_starve & w_f_ok);
  assign w_f_gnt = ~reset & w_f_ok & ~w_d_gnt;

`ifdef FETCH_STARVE_GUARD_EN
  imem_arb_age #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_age (
    .clock     (clock),
    .reset     (reset),
    .i_f_req   (bus.f_req),
    .i_f_flush (bus.f_flush),
    .i_f_gnt   (w_f_gnt),
    .i_d_gnt   (w_d_gnt),
    .o_starve  (w_starve)
  );
`else
  assign w_starve = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= MEM_READ;
    end else if (w_d_gnt) begin
      r_mem_addr  <= bus.d_addr;
      r_mem_wdata <= bus.d_wdata;
      r_mem_we    <= bus.d_we ? MEM_WRITE : MEM_READ;
    end else if (w_f_gnt) begin
      r_mem_addr  <= bus.f_addr;
      r_mem_wdata <= '0;
      r_mem_we    <= MEM_READ;
    end else begin
      r_mem_we    <= MEM_READ;
    end
  end

  // Stage 1 tracks the access the memory is serving now; a flush drops a fetch there.
  assign w_kill1 = bus.f_flush & (r_own1 == OWN_FETCH);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_own1 <= OWN_NONE;
      r_own2 <= OWN_NONE;
    end else begin
      r_own1 <= grant_owner(w_f_gnt, w_d_gnt, bus.d_we);
      r_own2 <= w_kill1 ? OWN_NONE : r_own1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_f_cap   <= '0;
      r_d_rdata <= '0;
    end else begin
      if ((r_own1 == OWN_FETCH) && !bus.f_flush) r_f_cap <= bus.mem_data_out;
      if (r_own1 == OWN_DATA)                    r_d_rdata <= bus.mem_data_out;
    end
  end

  // A flush arriving in the response cycle itself can only be honoured by masking.
  assign w_f_rvalid = ~reset & ~bus.f_flush & (r_own2 == OWN_FETCH);
  assign w_d_rvalid = ~reset & (r_own2 == OWN_DATA);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_f_hold <= '0;
    end else if (w_f_rvalid) begin
      r_f_hold <= r_f_cap;
    end
  end

  assign bus.f_gnt          = w_f_gnt;
  assign bus.d_gnt          = w_d_gnt;
  assign bus.f_rvalid       = w_f_rvalid;
  assign bus.f_rdata        = w_f_rvalid ? r_f_cap : r_f_hold;
  assign bus.d_rvalid       = w_d_rvalid;
  assign bus.d_rdata        = r_d_rdata;
  assign bus.mem_address    = r_mem_addr;
  assign bus.mem_data_in    = r_mem_wdata;
  assign bus.mem_read_write = r_mem_we;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: expected read responses are queued when a
// grant is seen and a negedge monitor pops and compares them against rvalid/rdata.
module tb_imem_arbiter;
  import pd_mem_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  imem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  imem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] fq[$];
  logic [31:0] dq[$];

  // Memory model: unwritten words read as ~address; one store is remembered.
  logic        m_v = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_d = '0;

  always_comb bus.mem_data_out = (m_v && (bus.mem_address == m_a)) ? m_d : ~bus.mem_address;

  always @(posedge clock) begin
    if (bus.mem_read_write) begin
      m_v <= 1'b1;
      m_a <= bus.mem_address;
      m_d <= bus.mem_data_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.f_rvalid) begin
      if (fq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL f_unexpected: f_rvalid=1 rdata=%h, expected no fetch response", bus.f_rdata);
      end else begin
        chk("f_rdata", bus.f_rdata, fq.pop_front());
      end
    end
    if (bus.d_rvalid) begin
      if (dq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL d_unexpected: d_rvalid=1 rdata=%h, expected no data response", bus.d_rdata);
      end else begin
        chk("d_rdata", bus.d_rdata, dq.pop_front());
      end
    end
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.f_flush = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_f;
    idle();
    reset = 1'b1;
    bus.f_req = 1'b1;
    bus.d_req = 1'b1;
    next();
    @(negedge clock);
    chk("rst_f_gnt", bus.f_gnt, 0);
    chk("rst_d_gnt", bus.d_gnt, 0);
    chk("rst_mem_addr", bus.mem_address, 0);
    chk("rst_mem_din", bus.mem_data_in, 0);
    chk("rst_mem_rw", bus.mem_read_write, MEM_READ);
    chk("rst_f_rvalid", bus.f_rvalid, 0);
    chk("rst_d_rvalid", bus.d_rvalid, 0);
    next();
    reset = 1'b0;
    idle();
    next();

    // Lone fetch
    bus.f_req = 1'b1; bus.f_addr = 32'h0100_0000;
    @(negedge clock);
    chk("t1_f_gnt", bus.f_gnt, 1);
    chk("t1_d_gnt", bus.d_gnt, 0);
    fq.push_back(32'hFEFF_FFFF);
    next(); idle();
    @(negedge clock);
    chk("t1_mem_addr", bus.mem_address, 32'h0100_0000);
    chk("t1_mem_rw", bus.mem_read_write, MEM_READ);
    next();
    @(negedge clock);
    chk("t1_f_rvalid", bus.f_rvalid, 1);
    next();

    // Fetch and load collide: data first
    bus.f_req = 1'b1; bus.f_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    @(negedge clock);
    chk("t2_d_gnt", bus.d_gnt, 1);
    chk("t2_f_gnt", bus.f_gnt, 0);
    dq.push_back(32'hFFFF_FEFF);
    next(); bus.d_req = 1'b0;
    @(negedge clock);
    chk("t2_f_gnt_next", bus.f_gnt, 1);
    fq.push_back(32'hFFFF_FDFF);
    next(); idle();
    @(negedge clock);
    chk("t2_d_rvalid_c2", bus.d_rvalid, 1);
    chk("t2_f_rvalid_c2", bus.f_rvalid, 0);
    next();
    @(negedge clock);
    chk("t2_f_rvalid_c3", bus.f_rvalid, 1);
    chk("t2_d_rvalid_c3", bus.d_rvalid, 0);
    next();

    // Store then load of the same word
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("t3_st_gnt", bus.d_gnt, 1);
    next(); bus.d_we = 1'b0; bus.d_wdata = '0;
    @(negedge clock);
    chk("t3_ld_gnt", bus.d_gnt, 1);
    chk("t3_mem_rw_st", bus.mem_read_write, MEM_WRITE);
    chk("t3_mem_addr", bus.mem_address, 32'h10);
    chk("t3_mem_din", bus.mem_data_in, 32'hDEAD_BEEF);
    dq.push_back(32'hDEAD_BEEF);
    next(); idle();
    @(negedge clock);
    chk("t3_mem_rw_ld", bus.mem_read_write, MEM_READ);
    chk("t3_st_no_rvalid", bus.d_rvalid, 0);
    next();
    @(negedge clock);
    chk("t3_mem_rw_idle", bus.mem_read_write, MEM_READ);
    chk("t3_ld_rvalid", bus.d_rvalid, 1);
    next();

    // Flush kills two in-flight fetches, leaves data alone
    bus.f_req = 1'b1; bus.f_addr = 32'h300;
    @(negedge clock);
    chk("t4_f_gnt0", bus.f_gnt, 1);
    next(); bus.f_addr = 32'h304;
    @(negedge clock);
    chk("t4_f_gnt1", bus.f_gnt, 1);
    next();
    bus.f_flush = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
    @(negedge clock);
    chk("t4_f_rvalid_c2", bus.f_rvalid, 0);
    chk("t4_d_gnt_flush", bus.d_gnt, 1);
    chk("t4_f_gnt_flush", bus.f_gnt, 0);
    dq.push_back(32'hFFFF_FFBB);
    next(); idle();
    @(negedge clock);
    chk("t4_f_rvalid_c3", bus.f_rvalid, 0);
    next();
    bus.f_flush = 1'b1; bus.f_req = 1'b1; bus.f_addr = 32'h308;
    @(negedge clock);
    chk("t4_f_gnt_blocked", bus.f_gnt, 0);
    chk("t4_d_rvalid_kept", bus.d_rvalid, 1);
    next(); bus.f_flush = 1'b0;
    @(negedge clock);
    chk("t4_f_gnt_after", bus.f_gnt, 1);
    fq.push_back(32'hFFFF_FCF7);
    next(); idle();
    next();
    @(negedge clock);
    chk("t4_f_rvalid_new", bus.f_rvalid, 1);
    next();

    // Both requesters held high
    bus.f_req = 1'b1; bus.f_addr = 32'h400;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
    for (int i = 0; i < 10; i++) begin
`ifdef FETCH_STARVE_GUARD_EN
      exp_f = ((i % 5) == 4);
`else
      exp_f = 1'b0;
`endif
      @(negedge clock);
      chk($sformatf("t5_f_gnt_%0d", i), bus.f_gnt, exp_f);
      chk($sformatf("t5_d_gnt_%0d", i), bus.d_gnt, !exp_f);
      if (exp_f) fq.push_back(32'hFFFF_FBFF);
      else       dq.push_back(32'hFFFF_FF7F);
      next();
    end
    idle();
    next(); next(); next();

    // Reset with two reads in flight
    bus.f_req = 1'b1; bus.f_addr = 32'h500;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600;
    @(negedge clock);
    chk("t6_d_gnt", bus.d_gnt, 1);
    next(); bus.d_req = 1'b0;
    @(negedge clock);
    chk("t6_f_gnt", bus.f_gnt, 1);
    next(); idle(); reset = 1'b1;
    @(negedge clock);
    chk("t6_d_rvalid_rst", bus.d_rvalid, 0);
    chk("t6_f_rvalid_rst", bus.f_rvalid, 0);
    next(); reset = 1'b0;
    @(negedge clock);
    chk("t6_f_rvalid_p1", bus.f_rvalid, 0);
    chk("t6_d_rvalid_p1", bus.d_rvalid, 0);
    next();
    @(negedge clock);
    chk("t6_f_rvalid_p2", bus.f_rvalid, 0);
    chk("t6_d_rvalid_p2", bus.d_rvalid, 0);
    next(); next(); next();

    chk("fq_drained", fq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
